// File: rtl/inst_pkg.sv
// Shared definitions for the RV32 instruction encoder: op codes, opcode and
// funct fields, format selects, error codes and controller states.
package inst_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_AND     = 4'd1,
        OP_SUB     = 4'd2,
        OP_SLT     = 4'd3,
        OP_DIV     = 4'd4,
        OP_REM     = 4'd5,
        OP_SLL     = 4'd6,
        OP_SRL     = 4'd7,
        OP_SRA     = 4'd8,
        OP_ADDI    = 4'd9,
        OP_LW      = 4'd10,
        OP_SW      = 4'd11,
        OP_BEQ     = 4'd12,
        OP_JAL     = 4'd13,
        OP_JALR    = 4'd14,
        OP_ILLEGAL = 4'd15
    } op_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // Same encoding as the core's immediate-control field.
    typedef enum logic [2:0] {
        FMT_R = 3'b000,
        FMT_I = 3'b001,
        FMT_S = 3'b010,
        FMT_B = 3'b011,
        FMT_U = 3'b100,
        FMT_J = 3'b101
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_ILLEGAL_OP = 2'd1,
        ERR_IMM_RANGE  = 2'd2,
        ERR_MISALIGN   = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_ERR,
        ST_DONE
    } state_e;

endpackage

// File: rtl/inst_fifo2.sv
// Two-entry valid/ready FIFO holding {word address, instruction}.
module inst_fifo2 #(
    parameter int             W       = 40,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q, wr_d, rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign valid_o = !empty_o;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (do_push) wr_d = ~wr_q;
            if (do_pop)  rd_d = ~rd_q;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= RST_VAL;
            mem_q[1] <= RST_VAL;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push && !flush_i) mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Encodes symbolic RV32 field tuples into instruction words tagged with an
// auto-incrementing word address, buffered in a 2-entry output FIFO.
module inst_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [20:0]       imm,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_inst,
    output logic [ADDR_W-1:0] m_addr,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);
    import inst_pkg::*;

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  words_q;
    logic              err_q;
    err_code_e         err_code_q;

    logic [6:0] opc_c, f7_c;
    logic [2:0] f3_c;
    fmt_e       fmt_c;
    logic       illegal_c;
    logic [31:0] inst_c;
    err_code_e  err_c;
    logic       fits12, fits13;
    logic       accept, push, last_push, bad_accept;
    logic       fifo_full, fifo_empty;

    always_comb begin
        opc_c     = OPC_R;
        f7_c      = F7_BASE;
        f3_c      = F3_ADD_SUB;
        fmt_c     = FMT_R;
        illegal_c = 1'b0;
        case (op_e'(op))
            OP_ADD:  ;
            OP_AND:  f3_c = F3_AND;
            OP_SUB:  f7_c = F7_ALT;
            OP_SLT:  f3_c = F3_SLT;
            OP_DIV:  begin f7_c = F7_MULDIV; f3_c = F3_DIV; end
            OP_REM:  begin f7_c = F7_MULDIV; f3_c = F3_REM; end
            OP_SLL:  f3_c = F3_SLL;
            OP_SRL:  f3_c = F3_SR;
            OP_SRA:  begin f7_c = F7_ALT; f3_c = F3_SR; end
            OP_ADDI: begin opc_c = OPC_IMM;    fmt_c = FMT_I; end
            OP_LW:   begin opc_c = OPC_LOAD;   f3_c = F3_WORD; fmt_c = FMT_I; end
            OP_SW:   begin opc_c = OPC_STORE;  f3_c = F3_WORD; fmt_c = FMT_S; end
            OP_BEQ:  begin opc_c = OPC_BRANCH; f3_c = F3_BEQ;  fmt_c = FMT_B; end
            OP_JAL:  begin opc_c = OPC_JAL;    fmt_c = FMT_J; end
            OP_JALR: begin opc_c = OPC_JALR;   f3_c = F3_JALR; fmt_c = FMT_I; end
            default: illegal_c = 1'b1;
        endcase
    end

    // An immediate fits N signed bits when everything above bit N-1 is a sign copy.
    assign fits12 = (&imm[20:11]) || !(|imm[20:11]);
    assign fits13 = (&imm[20:12]) || !(|imm[20:12]);

    always_comb begin
        inst_c = '0;
        err_c  = ERR_NONE;
        case (fmt_c)
            FMT_R: inst_c = {f7_c, rs2, rs1, f3_c, rd, opc_c};
            FMT_I: begin
                inst_c = {imm[11:0], rs1, f3_c, rd, opc_c};
                if (!fits12) err_c = ERR_IMM_RANGE;
            end
            FMT_S: begin
                inst_c = {imm[11:5], rs2, rs1, f3_c, imm[4:0], opc_c};
                if (!fits12) err_c = ERR_IMM_RANGE;
            end
            FMT_B: begin
                inst_c = {imm[12], imm[10:5], rs2, rs1, f3_c, imm[4:1], imm[11], opc_c};
                if (!fits13)     err_c = ERR_IMM_RANGE;
                else if (imm[0]) err_c = ERR_MISALIGN;
            end
            FMT_J: begin
                inst_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc_c};
                if (imm[0]) err_c = ERR_MISALIGN;
            end
            default: err_c = ERR_ILLEGAL_OP;
        endcase
        if (illegal_c) err_c = ERR_ILLEGAL_OP;
    end

    assign accept     = s_valid && s_ready && !start;
    assign push       = accept && (err_c == ERR_NONE);
    assign bad_accept = accept && (err_c != ERR_NONE);
    assign last_push  = push && (words_q == CNT_W'(MAX_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bad_accept)     state_d = ST_ERR;
                    else if (last_push) state_d = ST_DRAIN;
                end
                ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        s_ready = (state_q == ST_RUN) && !fifo_full;
        done    = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= ADDR_W'(BASE_ADDR);
            words_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (start) begin
            addr_q     <= ADDR_W'(BASE_ADDR);
            words_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (push) begin
                addr_q  <= addr_q + ADDR_W'(1);
                words_q <= words_q + CNT_W'(1);
            end
            if (bad_accept) begin
                err_q      <= 1'b1;
                err_code_q <= err_c;
            end
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;

    inst_fifo2 #(
        .W       (32 + ADDR_W),
        .RST_VAL ({ADDR_W'(BASE_ADDR), 32'h0})
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (start),
        .push_i  (push),
        .data_i  ({addr_q, inst_c}),
        .pop_i   (m_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .valid_o (m_valid),
        .data_o  ({m_addr, m_inst})
    );

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder with hand-computed instruction words.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n, start, s_valid, s_ready, m_valid, m_ready, done, err;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [20:0] imm;
    logic [31:0] m_inst;
    logic [7:0]  m_addr;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(8), .BASE_ADDR(0), .MAX_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_ready(s_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .m_valid(m_valid), .m_ready(m_ready), .m_inst(m_inst), .m_addr(m_addr),
        .done(done), .err(err), .err_code(err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Holds the tuple until accepted; returns one step after the accepting edge.
    task automatic send(input logic [3:0] o, input logic [4:0] d, input logic [4:0] a,
                        input logic [4:0] b, input logic [20:0] im);
        bit ok = 1'b0;
        op = o; rd = d; rs1 = a; rs2 = b; imm = im;
        s_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (s_ready) ok = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        if (!ok) check("send_timeout", {31'b0, s_ready}, 32'd1);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] inst, input logic [7:0] addr);
        check({tag, "_valid"}, {31'b0, m_valid}, 32'd1);
        check({tag, "_inst"}, m_inst, inst);
        check({tag, "_addr"}, {24'b0, m_addr}, {24'b0, addr});
    endtask

    task automatic expect_err(input string tag, input logic [1:0] code);
        check({tag, "_err"}, {31'b0, err}, 32'd1);
        check({tag, "_code"}, {30'b0, err_code}, {30'b0, code});
        check({tag, "_sready"}, {31'b0, s_ready}, 32'd0);
    endtask

    logic [31:0] exp_inst [3];
    int          got_n;
    bit          acc;

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        #1;
        repeat (3) tick();
        check("rst_sready", {31'b0, s_ready}, 32'd0);
        check("rst_mvalid", {31'b0, m_valid}, 32'd0);
        check("rst_minst", m_inst, 32'd0);
        check("rst_maddr", {24'b0, m_addr}, 32'd0);
        check("rst_done_err", {29'b0, done, err_code}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_sready", {31'b0, s_ready}, 32'd0);

        // Basic R-type, one cycle after accept
        pulse_start();
        check("run_sready", {31'b0, s_ready}, 32'd1);
        send(4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
        expect_word("add", 32'h002081B3, 8'd0);

        // Back-to-back
        pulse_start();
        send(4'd9, 5'd1, 5'd0, 5'd0, 21'd5);
        expect_word("addi", 32'h00500093, 8'd0);
        send(4'd2, 5'd5, 5'd6, 5'd7, 21'd0);
        expect_word("sub", 32'h407302B3, 8'd1);

        // Immediate boundaries that must encode
        pulse_start();
        send(4'd9, 5'd1, 5'd0, 5'd0, 21'd2047);
        expect_word("addi_max", 32'h7FF00093, 8'd0);
        send(4'd9, 5'd1, 5'd0, 5'd0, 21'h1FF800);
        expect_word("addi_min", 32'h80000093, 8'd1);
        send(4'd12, 5'd0, 5'd1, 5'd2, 21'd4094);
        expect_word("beq_max", 32'h7E208FE3, 8'd2);

        pulse_start();
        send(4'd12, 5'd0, 5'd1, 5'd2, 21'd8);
        expect_word("beq8", 32'h00208463, 8'd0);
        send(4'd13, 5'd1, 5'd0, 5'd0, 21'd16);
        expect_word("jal16", 32'h010000EF, 8'd1);

        // Four words with MAX_WORDS=4 -> DRAIN then DONE
        pulse_start();
        send(4'd10, 5'd2, 5'd1, 5'd0, 21'd8);
        expect_word("lw", 32'h0080A103, 8'd0);
        send(4'd11, 5'd0, 5'd1, 5'd2, 21'd4);
        expect_word("sw", 32'h0020A223, 8'd1);
        send(4'd14, 5'd1, 5'd2, 5'd0, 21'd0);
        expect_word("jalr", 32'h000100E7, 8'd2);
        send(4'd4, 5'd3, 5'd1, 5'd2, 21'd0);
        expect_word("div", 32'h0220C1B3, 8'd3);
        check("drain_sready", {31'b0, s_ready}, 32'd0);
        for (int i = 0; i < 20 && !done; i++) tick();
        check("done", {31'b0, done}, 32'd1);
        check("done_mvalid", {31'b0, m_valid}, 32'd0);
        pulse_start();
        check("done_cleared", {31'b0, done}, 32'd0);

        // Backpressure: FIFO fills after two, pop+push when full stays blocked
        m_ready = 1'b0;
        send(4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
        send(4'd9, 5'd1, 5'd0, 5'd0, 21'd5);
        check("full_sready", {31'b0, s_ready}, 32'd0);
        check("full_head", m_inst, 32'h002081B3);
        op = 4'd2; rd = 5'd5; rs1 = 5'd6; rs2 = 5'd7; imm = '0;
        s_valid = 1'b1;
        repeat (3) begin
            tick();
            check("hold_sready", {31'b0, s_ready}, 32'd0);
        end
        exp_inst[0] = 32'h002081B3;
        exp_inst[1] = 32'h00500093;
        exp_inst[2] = 32'h407302B3;
        got_n = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 12 && got_n < 3; i++) begin
            if (m_valid) begin
                check("drain_inst", m_inst, exp_inst[got_n]);
                check("drain_addr", {24'b0, m_addr}, got_n);
                got_n++;
            end
            acc = s_valid && s_ready;
            tick();
            if (acc) s_valid = 1'b0;
        end
        check("drain_count", got_n, 32'd3);

        // Error cases
        pulse_start();
        send(4'd9, 5'd1, 5'd0, 5'd0, 21'd2048);
        expect_err("addi_range", 2'd2);
        check("addi_range_nopush", {31'b0, m_valid}, 32'd0);
        pulse_start();
        check("err_cleared", {31'b0, err}, 32'd0);
        send(4'd12, 5'd0, 5'd1, 5'd2, 21'd3);
        expect_err("beq_odd", 2'd3);
        pulse_start();
        send(4'd12, 5'd0, 5'd1, 5'd2, 21'd4096);
        expect_err("beq_range", 2'd2);
        pulse_start();
        send(4'd13, 5'd1, 5'd0, 5'd0, 21'd7);
        expect_err("jal_odd", 2'd3);
        pulse_start();
        m_ready = 1'b0;
        send(4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
        send(4'd15, 5'd1, 5'd1, 5'd1, 21'd0);
        expect_err("illegal", 2'd1);
        expect_word("err_keep", 32'h002081B3, 8'd0);
        m_ready = 1'b1;
        tick();
        check("err_drained", {31'b0, m_valid}, 32'd0);

        // Reset with FIFO full
        pulse_start();
        m_ready = 1'b0;
        send(4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
        send(4'd9, 5'd1, 5'd0, 5'd0, 21'd5);
        check("pre_rst_full", {31'b0, s_ready, m_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mvalid", {31'b0, m_valid}, 32'd0);
        check("mid_rst_minst", m_inst, 32'd0);
        check("mid_rst_maddr", {24'b0, m_addr}, 32'd0);
        check("mid_rst_flags", {28'b0, s_ready, done, err_code}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_mvalid", {31'b0, m_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
